// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the program counter and the IF/ID pipeline
// register. Handles sequential fetch, hazard stalls, late branch redirects
// and ID-stage jump redirects, injecting a NOP bubble on every redirect.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   NOP_WORD        instruction word placed in IF/ID on reset or flush
//
// Ports
//   clk             clock, all state updates on rising edge
//   rst             synchronous active-high reset
//   pc              current fetch byte address (to instruction memory)
//   command         instruction word returned by memory for pc
//   stall           hazard hold: freeze pc and IF/ID
//   branch_taken    resolved taken branch: redirect and flush
//   branch_target   branch destination byte address
//   jump            jump decoded in ID: redirect and flush
//   jump_index      jump instruction bits [25:0]
//   if_id_instr     registered instruction for decode
//   if_id_pc_plus4  registered pc+4 of that instruction
//   if_id_valid     1 = real instruction, 0 = bubble
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   fetch_count     number of normal fetch edges (wraps)
//   stall_count     number of stall edges without branch_taken (wraps)
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'hFC000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] command,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_aligned;
    logic [XLEN-1:0] jump_target;

    // Sequential address and redirect targets; both targets are word aligned.
    always_comb begin
        pc_plus4       = pc + XLEN'(4);
        branch_aligned = branch_target & ~XLEN'(3);
        jump_target    = {if_id_pc_plus4[31:28], jump_index, 2'b00};
    end

    // PC and IF/ID register: rst > branch_taken > stall > jump > normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (branch_taken) begin
            pc             <= branch_aligned;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (stall) begin
            // Hold everything; a pending jump is re-presented by ID later.
            pc             <= pc;
            if_id_instr    <= if_id_instr;
            if_id_pc_plus4 <= if_id_pc_plus4;
            if_id_valid    <= if_id_valid;
        end else if (jump) begin
            pc             <= jump_target;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_plus4;
            if_id_instr    <= command;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: normal fetch edges and stall edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (!branch_taken) begin
            if (stall) begin
                stall_count <= stall_count + XLEN'(1);
            end else if (!jump) begin
                fetch_count <= fetch_count + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. Each scenario queues per-cycle
// stimulus and the expected post-edge state; expectations are popped and
// compared one edge at a time. Counter checks are active when the design is
// built with FETCH_PERF_CNT_EN.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hFC000000;
    localparam int K_NONE  = 0;
    localparam int K_NORM  = 1;
    localparam int K_STALL = 2;
    localparam int K_RST   = 3;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [25:0] ji;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] command;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] efc = 32'h0;
    logic [31:0] esc = 32'h0;
    stim_t stq[$];
    exp_t  sb[$];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .command        (command),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: two fixed words, address-derived elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0)      return 32'h8C0203E7;
        else if (a == 32'h4) return 32'h00001820;
        else                 return 32'h5A000000 ^ a;
    endfunction

    assign command = memf(pc);

    function automatic stim_t mk(input logic r, input logic s, input logic b,
                                 input logic [31:0] t, input logic j,
                                 input logic [25:0] x);
        stim_t v;
        v.rst = r; v.stall = s; v.br = b; v.bt = t; v.jmp = j; v.ji = x;
        return v;
    endfunction

    // Queue one cycle of stimulus with the state expected after its edge.
    task automatic push_cycle(input stim_t s, input logic [31:0] p,
                              input logic [31:0] i, input logic [31:0] p4,
                              input logic v, input int k);
        exp_t e;
        case (k)
            K_RST:   begin efc = 32'h0; esc = 32'h0; end
            K_NORM:  efc = efc + 32'd1;
            K_STALL: esc = esc + 32'd1;
            default: ;
        endcase
        e.pc = p; e.instr = i; e.pcp4 = p4; e.valid = v; e.fc = efc; e.sc = esc;
        stq.push_back(s);
        sb.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; stall = s.stall; branch_taken = s.br;
        branch_target = s.bt; jump = s.jmp; jump_index = s.ji;
    endtask

    task automatic test_reset();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(1, 1, 1, 32'd64, 1, 26'd7), 32'h0, NOP, 32'h0, 0, K_RST);
        push_cycle(mk(1, 0, 0, 32'd0, 0, 26'd0), 32'h0, NOP, 32'h0, 0, K_RST);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL reset[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL reset[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL reset[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL reset[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL reset[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL reset[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    task automatic test_sequential();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(0, 0, 0, 32'd0, 0, 26'd0), 32'd4,  32'h8C0203E7, 32'd4,  1, K_NORM);
        push_cycle(mk(0, 0, 0, 32'd0, 0, 26'd0), 32'd8,  32'h00001820, 32'd8,  1, K_NORM);
        push_cycle(mk(0, 0, 0, 32'd0, 0, 26'd0), 32'd12, memf(32'd8),  32'd12, 1, K_NORM);
        push_cycle(mk(0, 0, 0, 32'd0, 0, 26'd0), 32'd16, memf(32'd12), 32'd16, 1, K_NORM);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL seq[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL seq[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL seq[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL seq[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL seq[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL seq[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    task automatic test_stall();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(0, 1, 0, 32'd0, 0, 26'd0),        32'd16, memf(32'd12), 32'd16, 1, K_STALL);
        push_cycle(mk(0, 1, 0, 32'd0, 1, 26'h3FFFFFF),  32'd16, memf(32'd12), 32'd16, 1, K_STALL);
        push_cycle(mk(0, 0, 0, 32'd0, 0, 26'd0),        32'd20, memf(32'd16), 32'd20, 1, K_NORM);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL stall[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL stall[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL stall[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL stall[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL stall[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL stall[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    task automatic test_branch();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(0, 1, 1, 32'd52, 1, 26'd9), 32'd52, NOP,          32'd0,  0, K_NONE);
        push_cycle(mk(0, 0, 0, 32'd0,  0, 26'd0), 32'd56, memf(32'd52), 32'd56, 1, K_NORM);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL branch[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL branch[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL branch[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL branch[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL branch[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL branch[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    task automatic test_jump();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(0, 0, 1, 32'd48, 0, 26'd0), 32'd48, NOP,          32'd0,  0, K_NONE);
        push_cycle(mk(0, 0, 0, 32'd0,  0, 26'd0), 32'd52, memf(32'd48), 32'd52, 1, K_NORM);
        push_cycle(mk(0, 0, 0, 32'd0,  1, 26'd3), 32'd12, NOP,          32'd0,  0, K_NONE);
        push_cycle(mk(0, 0, 0, 32'd0,  0, 26'd0), 32'd16, memf(32'd12), 32'd16, 1, K_NORM);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL jump[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL jump[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL jump[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL jump[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL jump[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL jump[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    task automatic test_wrap();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(0, 0, 1, 32'hFFFFFFFF, 0, 26'd0), 32'hFFFFFFFC, NOP,                32'h0,        0, K_NONE);
        push_cycle(mk(0, 0, 0, 32'h0,        0, 26'd0), 32'h0,        memf(32'hFFFFFFFC), 32'h0,        1, K_NORM);
        push_cycle(mk(0, 0, 0, 32'h0,        0, 26'd0), 32'h4,        32'h8C0203E7,       32'h4,        1, K_NORM);
        push_cycle(mk(0, 0, 1, 32'hF0000011, 0, 26'd0), 32'hF0000010, NOP,                32'h0,        0, K_NONE);
        push_cycle(mk(0, 0, 0, 32'h0,        0, 26'd0), 32'hF0000014, memf(32'hF0000010), 32'hF0000014, 1, K_NORM);
        push_cycle(mk(0, 0, 0, 32'h0,        1, 26'd1), 32'hF0000004, NOP,                32'h0,        0, K_NONE);
        push_cycle(mk(0, 0, 0, 32'h0,        0, 26'd0), 32'hF0000008, memf(32'hF0000004), 32'hF0000008, 1, K_NORM);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL wrap[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL wrap[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL wrap[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL wrap[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL wrap[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL wrap[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    task automatic test_reset_redirect();
        stim_t s; exp_t e; int n = 0;
        push_cycle(mk(1, 1, 1, 32'd100, 1, 26'd5), 32'h0, NOP,          32'h0, 0, K_RST);
        push_cycle(mk(0, 0, 0, 32'd0,   0, 26'd0), 32'h4, 32'h8C0203E7, 32'h4, 1, K_NORM);
        push_cycle(mk(0, 1, 0, 32'd0,   0, 26'd0), 32'h4, 32'h8C0203E7, 32'h4, 1, K_STALL);
        push_cycle(mk(1, 1, 0, 32'd0,   0, 26'd0), 32'h0, NOP,          32'h0, 0, K_RST);
        push_cycle(mk(0, 0, 0, 32'd0,   0, 26'd0), 32'h4, 32'h8C0203E7, 32'h4, 1, K_NORM);
        while (stq.size() > 0) begin
            s = stq.pop_front(); drive(s); @(posedge clk); #1; e = sb.pop_front();
            total++; if (pc !== e.pc) begin bad++; $display("FAIL rstredir[%0d] pc got=%h want=%h", n, pc, e.pc); end
            total++; if (if_id_instr !== e.instr) begin bad++; $display("FAIL rstredir[%0d] instr got=%h want=%h", n, if_id_instr, e.instr); end
            total++; if (if_id_pc_plus4 !== e.pcp4) begin bad++; $display("FAIL rstredir[%0d] pcp4 got=%h want=%h", n, if_id_pc_plus4, e.pcp4); end
            total++; if (if_id_valid !== e.valid) begin bad++; $display("FAIL rstredir[%0d] valid got=%b want=%b", n, if_id_valid, e.valid); end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== e.fc) begin bad++; $display("FAIL rstredir[%0d] fetch_count got=%0d want=%0d", n, fetch_count, e.fc); end
            total++; if (stall_count !== e.sc) begin bad++; $display("FAIL rstredir[%0d] stall_count got=%0d want=%0d", n, stall_count, e.sc); end
`endif
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_wrap();
        test_reset_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'hFC000000, instruction word injected into IF/ID on reset or flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pc  output  32  current fetch byte address; drives the instruction memory address.
REQ-006 command  input  32  instruction word returned combinationally by instruction memory for pc.
REQ-007 stall  input  1  hazard unit hold request; freezes PC and IF/ID.
REQ-008 branch_taken  input  1  resolved taken branch from a later stage; redirect and flush.
REQ-009 branch_target  input  32  branch destination byte address.
REQ-010 jump  input  1  jump decoded in ID; redirect and flush.
REQ-011 jump_index  input  26  jump instruction bits [25:0].
REQ-012 if_id_instr  output  32  registered instruction for decode.
REQ-013 if_id_pc_plus4  output  32  registered pc+4 of that instruction.
REQ-014 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction, 0 = bubble.

Function
REQ-015 pc_plus4 SHALL be pc + 4, modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-016 Jump target SHALL be {if_id_pc_plus4[31:28], jump_index, 2'b00}.
REQ-017 Every loaded redirect target SHALL have bits [1:0] forced to 2'b00.
REQ-018 Next-state priority per cycle SHALL be: rst > branch_taken > stall > jump > normal.
REQ-019 branch_taken: pc <= branch_target; IF/ID <= {NOP_WORD, 0, valid 0}; overrides stall and jump in the same cycle.
REQ-020 stall (no branch_taken): pc and all IF/ID registers hold; a simultaneous jump is ignored, as ID re-presents it after the stall.
REQ-021 jump (no branch_taken, no stall): pc <= jump target; IF/ID <= {NOP_WORD, 0, valid 0}.
REQ-022 Normal: pc <= pc_plus4; if_id_instr <= command; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
REQ-023 Latency: an instruction at address A SHALL appear on if_id_instr exactly one cycle after pc = A with no stall or redirect.
REQ-024 Flush SHALL cost exactly one bubble cycle in IF/ID per redirect; the target instruction reaches IF/ID on the following edge.
REQ-025 command SHALL be sampled only on non-stall, non-redirect edges; the block adds no combinational path from command to pc.

Reset
REQ-026 On rst = 1 at a rising edge: pc <= RESET_PC, if_id_instr <= NOP_WORD, if_id_pc_plus4 <= 0, if_id_valid <= 0; all other inputs are ignored.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard that operation; first fetch after deassertion is from RESET_PC.
REQ-028 If FETCH_PERF_CNT_EN is defined, both counters SHALL reset to 0.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN: when defined, the block SHALL add outputs fetch_count (32) and stall_count (32).
REQ-030 fetch_count SHALL increment on each normal-path edge (REQ-022); stall_count SHALL increment on each stall edge without branch_taken; both wrap at 2^32.
REQ-031 When FETCH_PERF_CNT_EN is undefined, the counter ports and their logic SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Reset then 3 free-running cycles, memory[0]=32'h8C0203E7, memory[4]=32'h00001820 -> pc 0,4,8,12; if_id_instr 8C0203E7 then 00001820; valid 0 at first edge, then 1.
REQ-033 stall high 2 cycles at pc=16 -> pc stays 16, IF/ID unchanged for 2 edges; fetch resumes at 20; stall_count +2 when counters enabled.
REQ-034 branch_taken with branch_target=52 while stall=1 and jump=1 -> pc=52 next edge, if_id_instr=FC000000, valid=0; next edge IF/ID holds memory[52].
REQ-035 jump with jump_index=3, if_id_pc_plus4=52 -> pc=12 next edge, one bubble, then memory[12] in IF/ID.
REQ-036 pc forced to 32'hFFFFFFFC via branch (target 32'hFFFFFFFF -> aligned to FFFFFFFC) -> following pc = 0.
REQ-037 rst asserted on the same edge as branch_taken=1 -> pc=0, valid=0, counters 0.
